// File: rtl/piso_7bit_tx.sv
// Parallel-in serial-out transmitter: captures a WIDTH-bit word on a load
// handshake and shifts it out one bit per enabled cycle, then pulses done.
module piso_7bit_tx #(
  parameter int WIDTH     = 7,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] d,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for a word, load_ready raised when enabled
  // SHIFT | presenting the head bit of the shift register each cycle
  // DONE  | one-cycle done pulse before returning to IDLE
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             head;
  logic             run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (load_valid) begin
            sreg_d  = d;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
          // counter parks at WIDTH-1 on the last bit so it never overflows
          if (cnt_q == LAST) state_d = DONE;
          else               cnt_d   = cnt_q + CW'(1);
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    head       = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    run        = en & ~rst;
    load_ready = (state_q == IDLE)  & run;
    sout_valid = (state_q == SHIFT) & run;
    done       = (state_q == DONE)  & run;
    busy       = (state_q != IDLE)  & ~rst;
    sout       = (state_q == SHIFT) & ~rst & head;
  end

endmodule

// File: doc/piso_7bit_tx.md
PISO_7BIT_TX -- requirements
Module: piso_7bit_tx

Interface
REQ-001 Parameter WIDTH, default 7, number of bits per frame (legal range 2..16).
REQ-002 Parameter MSB_FIRST, default 1, bit order: 1 = d[WIDTH-1] first, 0 = d[0] first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  clock enable; 0 freezes all internal state.
REQ-006 load_valid  input  1  producer asserts when d holds a word to transmit.
REQ-007 d  input  WIDTH  parallel word to serialize.
REQ-008 load_ready  output  1  block can accept a word this cycle.
REQ-009 sout  output  1  serial data bit.
REQ-010 sout_valid  output  1  sout carries a frame bit this cycle.
REQ-011 busy  output  1  frame in progress (state not IDLE).
REQ-012 done  output  1  one-cycle pulse after the last bit of a frame.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, DONE, and only these.
REQ-014 The block SHALL drive load_ready = (state==IDLE) & en & ~rst.
REQ-015 A load SHALL occur at an edge where load_valid & load_ready: capture d into shift register, bit counter := 0, state := SHIFT.
REQ-016 load_valid while load_ready=0 SHALL be ignored; d is sampled only at the load edge.
REQ-017 In SHIFT the block SHALL drive sout_valid = en & ~rst, with sout = current head bit of the shift register (MSB if MSB_FIRST=1, else LSB).
REQ-018 At each edge in SHIFT with en=1, the shift register SHALL shift by one toward the head and the counter SHALL increment.
REQ-019 At an enabled edge in SHIFT with counter==WIDTH-1, state SHALL go to DONE.
REQ-020 In DONE the block SHALL drive done = en & ~rst, with sout_valid=0 and load_ready=0; the next enabled edge SHALL return state to IDLE.
REQ-021 Timing SHALL be as follows: load at edge E0; bit k (k=0..WIDTH-1) valid in the cycle after edge E0+k; done in the cycle after E0+WIDTH; load_ready back in the cycle after E0+WIDTH+1.
REQ-022 With en=0, state, counter, shift register and sout SHALL hold; sout_valid, done and load_ready SHALL be 0; busy SHALL remain unchanged.
REQ-023 Outside SHIFT, sout SHALL be 0.
REQ-024 busy SHALL be 1 exactly when state is SHIFT or DONE.
REQ-025 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never exceed WIDTH-1.
REQ-026 The block SHALL NOT support back-to-back frames; minimum spacing between load edges is WIDTH+2 cycles.

Reset
REQ-027 At an edge with rst=1, the block SHALL set state IDLE, shift register 0 and counter 0; rst SHALL take priority over en and load_valid.
REQ-028 While rst=1, load_ready, sout_valid, done, busy and sout SHALL all be 0.
REQ-029 rst asserted mid-frame SHALL discard the partial frame without a done pulse; load_ready SHALL return in the first cycle after rst deasserts with en=1.

Verification
REQ-030 Basic MSB-first frame: rst 1 cycle, en=1, d=7'b1011001 with load_valid for 1 cycle -> sout = 1,0,1,1,0,0,1 on 7 consecutive sout_valid cycles, then done=1 for one cycle, then load_ready=1.
REQ-031 LSB-first (MSB_FIRST=0), d=7'b0000011 -> sout = 1,1,0,0,0,0,0; busy=1 for exactly 8 cycles.
REQ-032 Enable stall: same frame, en=0 for 3 cycles after bit 2 -> sout_valid=0 and sout held for those 3 cycles; bits 3..6 resume unchanged; done arrives 3 cycles later than unstalled.
REQ-033 Load while busy: load_valid=1 with d=7'b1111111 during bit 4 -> ignored, and the current frame completes with the original bits.
REQ-034 Reset mid-frame: rst=1 during bit 3 -> all outputs 0 next cycle; no done pulse; a new load of 7'b0101010 then transmits correctly.
REQ-035 Bench SHALL check sout_valid, sout and done against a cycle-accurate model every cycle for 100 random frames with random en gaps.
